// File: rtl/nonogram_downscaler.sv
// nonogram_downscaler: reduces streamed binary image rows by BLOCKxBLOCK
// block thresholding, emitting one reduced row per BLOCK input rows.
module nonogram_downscaler #(
  parameter int IN_W   = 320,
  parameter int IN_H   = 240,
  parameter int BLOCK  = 8,
  parameter int THRESH = 32
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  start_in,
  input  logic                  row_valid_in,
  input  logic [IN_W-1:0]       row_in,
  output logic                  busy_out,
  output logic [IN_W/BLOCK-1:0] row_out,
  output logic                  row_valid_out,
  output logic                  done_out
);

  localparam int NB    = IN_W / BLOCK;
  localparam int OUT_H = IN_H / BLOCK;
  localparam int CW    = $clog2(BLOCK * BLOCK + 1);
  localparam int PW    = $clog2(BLOCK + 1);
  localparam int RW    = (BLOCK > 1) ? $clog2(BLOCK) : 1;
  localparam int OW    = (OUT_H > 1) ? $clog2(OUT_H + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   cnt [NB];
  logic [CW-1:0]   sum [NB];
  logic [NB-1:0]   bits;
  logic [RW-1:0]   row_cnt;
  logic [OW-1:0]   out_cnt;
  logic            accept;
  logic            last_row;
  logic            last_out;

  function automatic logic [PW-1:0] popcount(input logic [BLOCK-1:0] v);
    logic [PW-1:0] n;
    n = '0;
    for (int i = 0; i < BLOCK; i++) begin
      n = n + PW'(v[i]);
    end
    return n;
  endfunction

  assign accept   = (state == ACCUM) && row_valid_in;
  assign last_row = (row_cnt == RW'(BLOCK - 1));
  assign last_out = (out_cnt == OW'(OUT_H - 1));
  assign busy_out = (state != IDLE);

  // Running block sums include the current row so the emit needs no extra cycle
  always_comb begin
    sum  = '{default: '0};
    bits = '0;
    for (int k = 0; k < NB; k++) begin
      sum[k]  = cnt[k] + CW'(popcount(row_in[BLOCK*k +: BLOCK]));
      bits[k] = (sum[k] >= CW'(THRESH));
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start_in) state_nx = ACCUM;
      ACCUM:   if (accept && last_row && last_out) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      for (int k = 0; k < NB; k++) begin
        cnt[k] <= '0;
      end
      row_cnt       <= '0;
      out_cnt       <= '0;
      row_out       <= '0;
      row_valid_out <= 1'b0;
      done_out      <= 1'b0;
    end else begin
      row_valid_out <= 1'b0;
      done_out      <= (state == DONE);
      if ((state == IDLE) && start_in) begin
        for (int k = 0; k < NB; k++) begin
          cnt[k] <= '0;
        end
        row_cnt <= '0;
        out_cnt <= '0;
      end else if (accept) begin
        if (last_row) begin
          row_out       <= bits;
          row_valid_out <= 1'b1;
          for (int k = 0; k < NB; k++) begin
            cnt[k] <= '0;
          end
          row_cnt <= '0;
          out_cnt <= out_cnt + OW'(1);
        end else begin
          for (int k = 0; k < NB; k++) begin
            cnt[k] <= sum[k];
          end
          row_cnt <= row_cnt + RW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_nonogram_downscaler.sv
// tb_nonogram_downscaler: directed + randomized frames checked against
// a block-counting reference model of the downscaler.
module tb_nonogram_downscaler;

  localparam int IN_W   = 320;
  localparam int IN_H   = 240;
  localparam int BLOCK  = 8;
  localparam int THRESH = 32;
  localparam int OW     = IN_W / BLOCK;
  localparam int OH     = IN_H / BLOCK;

  logic            clk_in = 1'b0;
  logic            reset_in;
  logic            start_in;
  logic            row_valid_in;
  logic [IN_W-1:0] row_in;
  logic            busy_out;
  logic [OW-1:0]   row_out;
  logic            row_valid_out;
  logic            done_out;

  int total = 0;
  int bad   = 0;
  int strobes = 0;
  int dones   = 0;
  int overlap = 0;

  logic [IN_W-1:0] img [IN_H];
  logic [OW-1:0]   exp_row [OH];

  nonogram_downscaler #(
    .IN_W(IN_W), .IN_H(IN_H), .BLOCK(BLOCK), .THRESH(THRESH)
  ) dut (
    .clk_in(clk_in),
    .reset_in(reset_in),
    .start_in(start_in),
    .row_valid_in(row_valid_in),
    .row_in(row_in),
    .busy_out(busy_out),
    .row_out(row_out),
    .row_valid_out(row_valid_out),
    .done_out(done_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    #2;
    if (row_valid_out) strobes++;
    if (done_out) dones++;
    if (row_valid_out && done_out) overlap++;
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  task automatic build_ref();
    int n;
    for (int r = 0; r < OH; r++) begin
      for (int k = 0; k < OW; k++) begin
        n = 0;
        for (int y = 0; y < BLOCK; y++)
          for (int x = 0; x < BLOCK; x++)
            n += int'(img[r*BLOCK+y][k*BLOCK+x]);
        exp_row[r][k] = (n >= THRESH);
      end
    end
  endtask

  task automatic fill_const(input bit v);
    for (int r = 0; r < IN_H; r++) img[r] = {IN_W{v}};
  endtask

  task automatic fill_stripes();
    for (int r = 0; r < IN_H; r++)
      for (int k = 0; k < OW; k++)
        img[r][k*BLOCK +: BLOCK] = (k % 2 == 0) ? 8'hFF : 8'h00;
  endtask

  task automatic fill_thresh(input int n);
    fill_const(1'b0);
    for (int i = 0; i < n; i++) img[i/BLOCK][i%BLOCK] = 1'b1;
  endtask

  task automatic fill_random();
    for (int r = 0; r < IN_H; r++)
      for (int c = 0; c < IN_W / 32; c++)
        img[r][c*32 +: 32] = $urandom;
  endtask

  task automatic run_frame(input int gap_max, input bit noise);
    int s0;
    int d0;
    int g;
    build_ref();
    s0 = strobes;
    d0 = dones;
    @(negedge clk_in);
    start_in = 1'b1;
    row_valid_in = 1'b0;
    @(negedge clk_in);
    start_in = 1'b0;
    check("busy_start", 64'(busy_out), 64'd1);
    for (int r = 0; r < IN_H; r++) begin
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (g) begin
        row_valid_in = 1'b0;
        for (int c = 0; c < IN_W / 32; c++) row_in[c*32 +: 32] = $urandom;
        start_in = noise ? 1'($urandom_range(1, 0)) : 1'b0;
        @(negedge clk_in);
      end
      start_in = 1'b0;
      row_valid_in = 1'b1;
      row_in = img[r];
      @(negedge clk_in);
      row_valid_in = 1'b0;
      if (r % BLOCK == BLOCK - 1) begin
        check("strobe", 64'(row_valid_out), 64'd1);
        check("row", 64'(row_out), 64'(exp_row[r/BLOCK]));
      end else begin
        check("no_strobe", 64'(row_valid_out), 64'd0);
      end
    end
    check("done_early", 64'(done_out), 64'd0);
    check("busy_last", 64'(busy_out), 64'd1);
    @(negedge clk_in);
    check("done", 64'(done_out), 64'd1);
    check("busy_done", 64'(busy_out), 64'd0);
    @(negedge clk_in);
    check("done_once", 64'(done_out), 64'd0);
    check("strobe_cnt", 64'(strobes - s0), 64'(OH));
    check("done_cnt", 64'(dones - d0), 64'd1);
  endtask

  initial begin
    int s0;
    int d0;
    reset_in = 1'b1;
    start_in = 1'b0;
    row_valid_in = 1'b0;
    row_in = '0;
    repeat (3) @(negedge clk_in);
    check("rst_row", 64'(row_out), 64'd0);
    check("rst_rv", 64'(row_valid_out), 64'd0);
    check("rst_done", 64'(done_out), 64'd0);
    check("rst_busy", 64'(busy_out), 64'd0);
    reset_in = 1'b0;
    @(negedge clk_in);

    fill_const(1'b0);
    run_frame(0, 1'b0);

    fill_const(1'b1);
    run_frame(0, 1'b0);

    fill_thresh(THRESH - 1);
    run_frame(0, 1'b0);
    check("thr31_bit0", 64'(row_out[0]), 64'd0);

    fill_thresh(THRESH);
    run_frame(0, 1'b0);

    fill_stripes();
    run_frame(5, 1'b0);
    check("stripes_last", 64'(row_out), 64'h55_5555_5555);

    s0 = strobes;
    repeat (10) begin
      row_valid_in = 1'b1;
      row_in = {IN_W{1'b1}};
      @(negedge clk_in);
      check("idle_busy", 64'(busy_out), 64'd0);
    end
    row_valid_in = 1'b0;
    @(negedge clk_in);
    check("idle_strobes", 64'(strobes - s0), 64'd0);

    fill_random();
    run_frame(3, 1'b1);

    fill_const(1'b1);
    build_ref();
    @(negedge clk_in);
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    for (int r = 0; r < 100; r++) begin
      row_valid_in = 1'b1;
      row_in = img[r];
      @(negedge clk_in);
    end
    row_valid_in = 1'b0;
    reset_in = 1'b1;
    @(negedge clk_in);
    s0 = strobes;
    d0 = dones;
    check("abort_row", 64'(row_out), 64'd0);
    check("abort_rv", 64'(row_valid_out), 64'd0);
    check("abort_busy", 64'(busy_out), 64'd0);
    repeat (2) @(negedge clk_in);
    reset_in = 1'b0;
    repeat (20) @(negedge clk_in);
    check("abort_strobes", 64'(strobes - s0), 64'd0);
    check("abort_dones", 64'(dones - d0), 64'd0);
    check("post_row", 64'(row_out), 64'd0);
    check("post_busy", 64'(busy_out), 64'd0);
    run_frame(0, 1'b0);

    check("no_overlap", 64'(overlap), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
